// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP layer sequencing logic.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_BIAS  = 3'd4,
    S_ACT   = 3'd5,
    S_WB    = 3'd6,
    S_DONE  = 3'd7
  } seq_state_t;

  localparam logic LAYER_HID = 1'b0;
  localparam logic LAYER_OUT = 1'b1;

  localparam int IN_LEN_HID = 784;
  localparam int IN_LEN_OUT = 32;
  localparam int NUM_LANES  = 32;

endpackage

// File: rtl/mlp_layer_sequencer_addr_counter.sv
// Load/clear/increment address counter that saturates at a terminal value.
module seq_addr_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Clear wins over load; increments stop once the terminal value is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control FSM for one fully-connected layer: clear, MAC stream, bias, optional
// ReLU, write-back. Issues addresses and single-cycle enables only.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_layer_sel,
  input  logic [ADDR_W:0]   i_in_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_acc_clr,
  output logic [ADDR_W-1:0] o_in_addr,
  output logic [ADDR_W:0]   o_w_addr,
  output logic              o_mac_en,
  output logic              o_bias_en,
  output logic              o_relu_en,
  output logic              o_act_we,
  output logic              o_logit_we
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t      r_state;
  logic            r_layer;
  logic [ADDR_W:0] r_len;
  logic            r_busy;
  logic            r_done;
  logic            r_acc_clr;
  logic            r_mac_en;
  logic            r_bias_en;
  logic            r_relu_en;
  logic            r_act_we;
  logic            r_logit_we;

  logic              w_accept;
  logic              w_inc;
  logic              w_tc;
  logic [ADDR_W-1:0] w_last;
  logic [ADDR_W-1:0] w_cnt;
  logic [ADDR_W:0]   w_len_clamped;

  assign w_accept      = (r_state == S_IDLE) && i_start;
  assign w_inc         = (r_state == S_MAC);
  assign w_len_clamped = (i_in_len > MAX_LEN) ? MAX_LEN : i_in_len;
  // For a clamped length of 2^ADDR_W the low bits are zero, so this wraps to all-ones.
  assign w_last        = r_len[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_addr_counter #(
    .W(ADDR_W)
  ) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_load     (1'b0),
    .i_load_val ({ADDR_W{1'b0}}),
    .i_inc      (w_inc),
    .i_last     (w_last),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // Sequencer state and Moore outputs, all decoded into registers at the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_layer    <= 1'b0;
      r_len      <= {(ADDR_W+1){1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_mac_en   <= 1'b0;
      r_bias_en  <= 1'b0;
      r_relu_en  <= 1'b0;
      r_act_we   <= 1'b0;
      r_logit_we <= 1'b0;
    end else begin
      // Delayed by one cycle to line up with the read latency of the buffers.
      r_mac_en   <= (r_state == S_MAC);
      r_done     <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_bias_en  <= 1'b0;
      r_relu_en  <= 1'b0;
      r_act_we   <= 1'b0;
      r_logit_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_layer   <= i_layer_sel;
            r_len     <= w_len_clamped;
            r_busy    <= 1'b1;
            r_acc_clr <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_len != {(ADDR_W+1){1'b0}}) begin
            r_state <= S_MAC;
          end else begin
            r_bias_en <= 1'b1;
            r_state   <= S_BIAS;
          end
        end
        S_MAC: begin
          if (w_tc) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_bias_en <= 1'b1;
          r_state   <= S_BIAS;
        end
        S_BIAS: begin
          if (r_layer == LAYER_HID) begin
            r_relu_en <= 1'b1;
            r_state   <= S_ACT;
          end else begin
            r_logit_we <= 1'b1;
            r_state    <= S_WB;
          end
        end
        S_ACT: begin
          r_act_we <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_acc_clr  = r_acc_clr;
  assign o_in_addr  = w_cnt;
  assign o_w_addr   = {r_layer, w_cnt};
  assign o_mac_en   = r_mac_en;
  assign o_bias_en  = r_bias_en;
  assign o_relu_en  = r_relu_en;
  assign o_act_we   = r_act_we;
  assign o_logit_we = r_logit_we;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench: per-cycle output trace compared against a schedule model.
module tb_mlp_layer_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          layer_sel;
  logic [AW:0]   in_len;
  logic          busy, done, acc_clr, mac_en, bias_en, relu_en, act_we, logit_we;
  logic [AW-1:0] in_addr;
  logic [AW:0]   w_addr;

  typedef logic [28:0] vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  int   exp_macs;

  mlp_layer_sequencer #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_layer_sel(layer_sel),
    .i_in_len   (in_len),
    .o_busy     (busy),
    .o_done     (done),
    .o_acc_clr  (acc_clr),
    .o_in_addr  (in_addr),
    .o_w_addr   (w_addr),
    .o_mac_en   (mac_en),
    .o_bias_en  (bias_en),
    .o_relu_en  (relu_en),
    .o_act_we   (act_we),
    .o_logit_we (logit_we)
  );

  always #5 clk = ~clk;

  function automatic vec_t observed();
    return {busy, done, acc_clr, mac_en, bias_en, relu_en, act_we, logit_we, in_addr, w_addr};
  endfunction

  // Expected outputs for cycles 1..done+1 after the start cycle, from the layer schedule.
  task automatic build(input bit layer, input int len);
    int n, b, dn, addr;
    logic [9:0] a10;
    n  = (len > 1024) ? 1024 : len;
    b  = (n > 0) ? n + 3 : 2;
    dn = layer ? b + 2 : b + 3;
    exp_macs = n;
    exp_q.delete();
    exp_q.push_back('0);
    for (int k = 1; k <= dn + 1; k++) begin
      if (n == 0 || k < 2) addr = 0;
      else if (k <= n + 1) addr = k - 2;
      else addr = n - 1;
      a10 = addr[9:0];
      exp_q.push_back({(k <= dn), (k == dn), (k == 1),
                       (n > 0 && k >= 3 && k <= n + 2), (k == b),
                       (!layer && k == b + 1), (!layer && k == b + 2),
                       (layer && k == b + 1), a10, layer, a10});
    end
  endtask

  // Assumes the caller is just past a falling edge; start is presented this cycle.
  task automatic run_layer(input bit layer, input int len, input bit noise, input string name);
    int macs;
    logic [31:0] r;
    macs = 0;
    build(layer, len);
    start     = 1'b1;
    layer_sel = layer;
    r         = len;
    in_len    = r[AW:0];
    for (int k = 1; k < exp_q.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mac_en) macs++;
      n_checks++;
      if (observed() !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, observed(), exp_q[k]);
      end
      if (noise && k < exp_q.size() - 1) begin
        r         = $urandom;
        start     = r[12];
        layer_sel = r[11];
        in_len    = r[AW:0];
      end
    end
    start = 1'b0;
    n_checks++;
    if (macs != exp_macs) begin
      n_fail++;
      $display("FAIL %s mac_count: got %0d expected %0d", name, macs, exp_macs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; layer_sel = 1'b0; in_len = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_layer(1'b0, 4, 1'b0, "hidden_len4");
    run_layer(1'b1, 32, 1'b0, "output_len32");
    run_layer(1'b0, 0, 1'b0, "hidden_len0");
    run_layer(1'b1, 0, 1'b0, "output_len0");
    run_layer(1'b0, 2000, 1'b0, "clamp_len2000");
  endtask

  task automatic test_start_while_busy();
    run_layer(1'b0, 20, 1'b1, "noise_hidden");
    run_layer(1'b1, 9, 1'b1, "noise_output");
  endtask

  task automatic test_back_to_back();
    run_layer(1'b1, 3, 1'b0, "b2b_first");
    run_layer(1'b0, 1, 1'b0, "b2b_second");
    run_layer(1'b0, 1024, 1'b0, "len_max");
  endtask

  task automatic test_reset_mid_mac();
    start = 1'b1; layer_sel = 1'b0; in_len = 11'd300;
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (in_addr !== 10'd100) begin
      n_fail++;
      $display("FAIL mid_mac_addr: got %0d expected 100", in_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL mid_mac_reset: got %h expected 0", observed());
    end
    rst = 1'b0;
    run_layer(1'b0, 6, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    logic [31:0] r;
    int len;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      if (r[3:1] == 3'd0) len = int'($urandom_range(1025, 2047));
      else len = int'($urandom_range(0, 40));
      run_layer(r[0], len, r[4], "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_mac();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
